// File: rtl/four_channel_rr_arbiter_if.sv
// rtl/four_channel_rr_arbiter_if.sv - producer/consumer bus of the four-channel round-robin arbiter
// Ports (signals):
//   a, b, c, d  WIDTH  channel 0..3 data (producer -> arbiter)
//   v           4      per-channel valid, v[0]=a .. v[3]=d
//   r           4      per-channel ready, same bit order as v
//   s           2      registered select: channel whose word is in y
//   y           WIDTH  registered output data
//   y_valid     1      y holds a word
//   y_ready     1      consumer accepts y this cycle
// Modports: master = producers + consumer (environment), slave = arbiter.
interface four_channel_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [3:0]       v;
  logic [3:0]       r;
  logic [1:0]       s;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;

  modport master (
    output a, b, c, d, v, y_ready,
    input  r, s, y, y_valid
  );

  modport slave (
    input  a, b, c, d, v, y_ready,
    output r, s, y, y_valid
  );
endinterface

// File: rtl/four_channel_rr_arbiter.sv
// rtl/four_channel_rr_arbiter.sv - 4:1 round-robin arbiter with a single registered output stage
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport of four_channel_rr_arbiter_if (a..d, v, r, s, y, y_valid, y_ready)
// One output register: a new word may load whenever the register is empty or is
// being drained this cycle, giving one word per cycle in steady state.
module four_channel_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  four_channel_rr_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       last_q;
  logic [1:0]       s_q;
  logic [WIDTH-1:0] y_q;

  logic             load;
  logic             grant_found;
  logic [1:0]       grant_idx;
  logic [WIDTH-1:0] grant_data;

  assign bus.y_valid = (state_q == FULL);
  assign bus.y       = y_q;
  assign bus.s       = s_q;

  assign load = (state_q == EMPTY) | (bus.y_valid & bus.y_ready);

  // Scan last+1 .. last+4 (mod 4); the channel granted last has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!grant_found && bus.v[last_q + 2'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = last_q + 2'(k);
      end
    end
  end

  always_comb begin
    grant_data = bus.a;
    case (grant_idx)
      2'd0: grant_data = bus.a;
      2'd1: grant_data = bus.b;
      2'd2: grant_data = bus.c;
      2'd3: grant_data = bus.d;
      default: grant_data = bus.a;
    endcase
  end

  // Ready is one-hot on the granted channel; forced low during reset so no
  // producer believes it handed over a word that the reset is about to clear.
  always_comb begin
    bus.r = 4'b0000;
    if (!rst && load && grant_found) begin
      bus.r[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= 2'b11;
      s_q     <= 2'b00;
      y_q     <= '0;
    end else if (load) begin
      if (grant_found) begin
        // Transfer (possibly pop and push on the same edge).
        state_q <= FULL;
        y_q     <= grant_data;
        s_q     <= grant_idx;
        last_q  <= grant_idx;
      end else begin
        // Drained with nothing to refill, or idle: y and s keep their values.
        state_q <= EMPTY;
      end
    end
  end

endmodule
